// File: rtl/encoder_if.sv
// Bit-in / symbol-out connection of the rate-1/2 convolutional encoder.
// The source side drives the information bit and mode select, the encoder drives the symbol.
interface encoder_if;
  logic       unencoded_bit;
  logic       choose_constraint_length;
  logic [1:0] out;

  modport master (output unencoded_bit, output choose_constraint_length, input out);
  modport slave  (input unencoded_bit, input choose_constraint_length, output out);
endinterface

// File: rtl/encoder.sv
// Rate-1/2 convolutional encoder, K=3 (7,5 octal) or K=7 (171,133 octal) selected per edge.
// One bit in and one registered 2-bit symbol out on every clock; no handshake.
module encoder (
  input  logic     clk,
  input  logic     rst_n,
  encoder_if.slave bus
);

  typedef enum logic {
    MODE_K3 = 1'b0,
    MODE_K7 = 1'b1
  } mode_e;

  logic [5:0] shift_q, shift_d;
  logic [1:0] out_q, out_d;
  mode_e      mode;
  logic       u;
  logic       g0, g1;

  assign u    = bus.unencoded_bit;
  assign mode = mode_e'(bus.choose_constraint_length);

  // Taps read the history as it stands before this edge, so a mode change reuses existing history.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (mode)
      MODE_K3: begin
        g0 = u ^ shift_q[0] ^ shift_q[1];
        g1 = u ^ shift_q[1];
      end
      MODE_K7: begin
        g0 = u ^ shift_q[0] ^ shift_q[1] ^ shift_q[2] ^ shift_q[5];
        g1 = u ^ shift_q[1] ^ shift_q[2] ^ shift_q[4] ^ shift_q[5];
      end
      default: begin
        g0 = 1'b0;
        g1 = 1'b0;
      end
    endcase
  end

  // All six history bits shift in both modes; only the tap selection depends on mode.
  always_comb begin
    shift_d = {shift_q[4:0], u};
    out_d   = {g0, g1};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 6'b0;
      out_q   <= 2'b00;
    end else begin
      shift_q <= shift_d;
      out_q   <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_encoder.sv
// Directed bench for the convolutional encoder: hand-computed symbol sequences for both
// constraint lengths, mode switching with retained history, and asynchronous reset behaviour.
module tb_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  encoder_if bus ();

  encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [1:0] expected);
    checks++;
    assert (bus.out === expected)
      else begin
        errors++;
        $error("FAIL %s: out=%b expected=%b", tag, bus.out, expected);
      end
  endtask

  // Drive inputs on the falling edge, let the rising edge consume them, sample 1 time unit later.
  task automatic step(input logic u, input logic mode, input logic [1:0] expected, input string tag);
    @(negedge clk);
    bus.unencoded_bit            = u;
    bus.choose_constraint_length = mode;
    @(posedge clk);
    #1;
    check_out(tag, expected);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n                        = 1'b0;
    bus.unencoded_bit            = 1'b0;
    bus.choose_constraint_length = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks                       = 0;
    errors                       = 0;
    rst_n                        = 1'b0;
    bus.unencoded_bit            = 1'b0;
    bus.choose_constraint_length = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // K=3 sequence 1,0,1,1,0,0
    step(1'b1, 1'b0, 2'b11, "k3_seq_e1");
    step(1'b0, 1'b0, 2'b10, "k3_seq_e2");
    step(1'b1, 1'b0, 2'b00, "k3_seq_e3");
    step(1'b1, 1'b0, 2'b01, "k3_seq_e4");
    step(1'b0, 1'b0, 2'b01, "k3_seq_e5");
    step(1'b0, 1'b0, 2'b11, "k3_seq_e6");

    // K=7 impulse response
    do_reset();
    step(1'b1, 1'b1, 2'b11, "k7_imp_e1");
    step(1'b0, 1'b1, 2'b10, "k7_imp_e2");
    step(1'b0, 1'b1, 2'b11, "k7_imp_e3");
    step(1'b0, 1'b1, 2'b11, "k7_imp_e4");
    step(1'b0, 1'b1, 2'b00, "k7_imp_e5");
    step(1'b0, 1'b1, 2'b01, "k7_imp_e6");
    step(1'b0, 1'b1, 2'b11, "k7_imp_e7");
    step(1'b0, 1'b1, 2'b00, "k7_imp_e8");

    // All-zero input in each mode from a clean state
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'b00, "k3_zero");
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'b00, "k7_zero");

    // Asynchronous reset between edges mid-stream
    do_reset();
    step(1'b1, 1'b0, 2'b11, "midrst_pre_e1");
    step(1'b1, 1'b0, 2'b01, "midrst_pre_e2");
    #2;
    rst_n = 1'b0;
    #1;
    check_out("midrst_async_clear", 2'b00);
    @(negedge clk);
    bus.unencoded_bit = 1'b0;
    rst_n             = 1'b1;
    step(1'b1, 1'b0, 2'b11, "midrst_post_e1");
    step(1'b0, 1'b0, 2'b10, "midrst_post_e2");

    // Mode switch keeps history: K=3 1,1 then K=7 0
    do_reset();
    step(1'b1, 1'b0, 2'b11, "switch_e1");
    step(1'b1, 1'b0, 2'b01, "switch_e2");
    step(1'b0, 1'b1, 2'b01, "switch_e3_k7");

    // Reset held while clock and inputs toggle
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.unencoded_bit            = ~bus.unencoded_bit;
      bus.choose_constraint_length = i[1];
      @(posedge clk);
      #1;
      check_out("held_reset", 2'b00);
    end
    @(negedge clk);
    bus.unencoded_bit            = 1'b0;
    bus.choose_constraint_length = 1'b1;
    rst_n                        = 1'b1;
    step(1'b1, 1'b1, 2'b11, "post_hold_e1");
    step(1'b0, 1'b1, 2'b10, "post_hold_e2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
